div_by_n_stream: RTL

// - Multi-channel serial divisibility checker: each channel takes one bit per valid beat.
// - Tracks the running remainder of the accumulated binary number modulo DIVISOR.
// - O(log2 DIVISOR) state per channel, so number length is unbounded; no wide shift register.
// - Sits after serial/bit-stream front ends; supports MSB-first or LSB-first streams.

---
 rtl/div_by_n_stream.sv | 87 ++++++++
 1 files changed

// File: rtl/div_by_n_stream.sv
// Multi-channel serial divisibility checker: each channel folds one bit per valid
// beat into a running remainder modulo DIVISOR, MSB-first or LSB-first.
module div_by_n_stream #(
    parameter int DIVISOR   = 3,
    parameter int CHANNELS  = 1,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 16,
    localparam int REM_W    = $clog2(DIVISOR)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       valid_i,
    input  logic [CHANNELS-1:0]       start_i,
    input  logic [CHANNELS-1:0]       x_i,
    output logic [CHANNELS-1:0]       valid_o,
    output logic [CHANNELS-1:0]       div_o,
    output logic [CHANNELS*REM_W-1:0] rem_o,
    output logic [CHANNELS*CNT_W-1:0] len_o,
    output logic [CHANNELS-1:0]       len_sat_o
);

    localparam logic [REM_W:0]   DIV_C   = (REM_W + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0] LEN_MAX = '1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [REM_W-1:0] rem_q, rem_d, w_q, w_d;
        logic [REM_W-1:0] rem_base, w_base;
        logic [REM_W:0]   sum, w_dbl;
        logic [CNT_W-1:0] len_q, len_d;
        logic             sat_q, sat_d, div_q, valid_q;

        // A start bit is folded in against the empty number (rem=0, w=1), so the
        // restart case shares the normal compare-subtract datapath.
        always_comb begin
            rem_base = start_i[c] ? '0 : rem_q;
            w_base   = start_i[c] ? REM_W'(1) : w_q;
            if (LSB_FIRST != 0) begin
                sum = {1'b0, rem_base} + (x_i[c] ? {1'b0, w_base} : '0);
            end else begin
                sum = {rem_base, x_i[c]};
            end
            w_dbl = {w_base, 1'b0};

            rem_d = rem_q;
            w_d   = w_q;
            len_d = len_q;
            sat_d = sat_q;
            if (valid_i[c]) begin
                rem_d = (sum >= DIV_C) ? REM_W'(sum - DIV_C) : sum[REM_W-1:0];
                w_d   = (w_dbl >= DIV_C) ? REM_W'(w_dbl - DIV_C) : w_dbl[REM_W-1:0];
                if (start_i[c]) begin
                    len_d = CNT_W'(1);
                    sat_d = 1'b0;
                end else if (len_q == LEN_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    len_d = len_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rem_q   <= '0;
                w_q     <= REM_W'(1);
                len_q   <= '0;
                sat_q   <= 1'b0;
                div_q   <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                rem_q   <= rem_d;
                w_q     <= w_d;
                len_q   <= len_d;
                sat_q   <= sat_d;
                div_q   <= (rem_d == '0);
                valid_q <= valid_i[c];
            end
        end

        assign rem_o[c*REM_W +: REM_W] = rem_q;
        assign len_o[c*CNT_W +: CNT_W] = len_q;
        assign len_sat_o[c]            = sat_q;
        assign div_o[c]                = div_q;
        assign valid_o[c]              = valid_q;
    end

endmodule
